// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU paths: FSM encoding, default width
// and the derived bit-counter width.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Counter must be able to hold WIDTH-1; sized for WIDTH+1 values for headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder shared by the bit-serial arithmetic paths.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder evaluation per clock, LSB first,
// WIDTH cycles per operation with a start / data_ready handshake.
module serial_addsub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             data_ready
);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_out_r;
  logic               overflow_r;
  logic               sum_s;
  logic               cout_s;
  logic               accept_s;
  logic               last_s;
  logic               busy_s;
  logic               data_ready_s;

  fa u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // A request is only taken when no operation is in flight.
  assign accept_s = start & ((state_r == IDLE) | (state_r == DONE));
  assign last_s   = (state_r == RUN) & (cnt_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE can chain straight into RUN without an idle bubble.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decode the state register only, so start never reaches them.
  always_comb begin
    busy_s       = 1'b0;
    data_ready_s = 1'b0;
    case (state_r)
      RUN:     busy_s       = 1'b1;
      DONE:    data_ready_s = 1'b1;
      default: begin
        busy_s       = 1'b0;
        data_ready_s = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and result/flag capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1, with the +1 entering as the initial carry.
      a_sh_r  <= op_a;
      b_sh_r  <= op_b ^ {WIDTH{sub}};
      carry_r <= sub;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      carry_r  <= cout_s;
      cnt_r    <= cnt_r + CNT_W'(1);
      result_r <= {sum_s, result_r[WIDTH-1:1]};
      if (last_s) begin
        carry_out_r <= cout_s;
        overflow_r  <= carry_r ^ cout_s;
      end
    end
  end

  assign result     = result_r;
  assign carry_out  = carry_out_r;
  assign overflow   = overflow_r;
  assign busy       = busy_s;
  assign data_ready = data_ready_s;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at WIDTH=32 and WIDTH=4.
module tb_serial_addsub;
  import serial_alu_pkg::*;

  logic        clock;
  logic        reset;
  logic        start32, sub32;
  logic [31:0] a32, b32, result32;
  logic        co32, ov32, busy32, dr32;
  logic        start4, sub4;
  logic [3:0]  a4, b4, result4;
  logic        co4, ov4, busy4, dr4;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub #(.WIDTH(32)) d32 (
    .clock(clock), .reset(reset), .start(start32), .sub(sub32),
    .op_a(a32), .op_b(b32), .result(result32), .carry_out(co32),
    .overflow(ov32), .busy(busy32), .data_ready(dr32)
  );

  serial_addsub #(.WIDTH(4)) d4 (
    .clock(clock), .reset(reset), .start(start4), .sub(sub4),
    .op_a(a4), .op_b(b4), .result(result4), .carry_out(co4),
    .overflow(ov4), .busy(busy4), .data_ready(dr4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w4, input logic st, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (w4) begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0]; sub4 = s;
    end else begin
      start32 = st; a32 = a; b32 = b; sub32 = s;
    end
  endtask

  // Entered and left just after a falling edge. poke>0 raises a stray start
  // (A=1,B=1,add) at that edge count while the operation is running.
  task automatic do_op(input bit w4, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int poke, output logic [31:0] res, output logic co, output logic ov,
                       output int edges, output int busy_n);
    logic rdy;
    edges  = 0;
    busy_n = 0;
    rdy    = 1'b0;
    drive(w4, 1'b1, a, b, s);
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == poke) drive(w4, 1'b1, 32'd1, 32'd1, 1'b0);
      else if (w4) start4 = 1'b0;
      else start32 = 1'b0;
      if (w4 ? busy4 : busy32) busy_n++;
      rdy = w4 ? dr4 : dr32;
    end while (!rdy && edges < 100);
    if (!rdy) check_eq("timeout", 64'd0, 64'd1);
    res = w4 ? {28'd0, result4} : result32;
    co  = w4 ? co4 : co32;
    ov  = w4 ? ov4 : ov32;
  endtask

  initial begin
    logic [31:0] r;
    logic        co, ov;
    int          e, bn, cnt;
    logic [3:0]  ra, rb, bb;
    logic        rs;
    logic [4:0]  full;

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_result", {32'd0, result32}, 64'd0);
    check_eq("rst_flags", {60'd0, co32, ov32, busy32, dr32}, 64'd0);

    // Simultaneous reset and start: reset wins.
    drive(1'b0, 1'b1, 32'd5, 32'd5, 1'b0);
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_vs_start_busy", {63'd0, busy32}, 64'd0);
    start32 = 1'b0;
    reset   = 1'b0;
    @(negedge clock);

    // 1: basic add, latency and busy length.
    do_op(1'b0, 32'd5, 32'd7, 1'b0, 0, r, co, ov, e, bn);
    check_eq("t1_edges", 64'(e), 64'd33);
    check_eq("t1_busy", 64'(bn), 64'd32);
    check_eq("t1_res", {32'd0, r}, 64'd12);
    check_eq("t1_flags", {62'd0, co, ov}, 64'd0);
    @(negedge clock);
    check_eq("t1_dr_pulse", {63'd0, dr32}, 64'd0);
    check_eq("t1_hold", {32'd0, result32}, 64'd12);

    // 2: positive overflow and unsigned wrap.
    do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, r, co, ov, e, bn);
    check_eq("t2a_res", {32'd0, r}, 64'h8000_0000);
    check_eq("t2a_flags", {62'd0, co, ov}, 64'd1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, r, co, ov, e, bn);
    check_eq("t2b_res", {32'd0, r}, 64'd0);
    check_eq("t2b_flags", {62'd0, co, ov}, 64'd2);

    // 3: subtraction with borrow, and negative-minus-positive overflow.
    do_op(1'b0, 32'd3, 32'd5, 1'b1, 0, r, co, ov, e, bn);
    check_eq("t3a_res", {32'd0, r}, 64'hFFFF_FFFE);
    check_eq("t3a_flags", {62'd0, co, ov}, 64'd0);
    do_op(1'b0, 32'h8000_0000, 32'd1, 1'b1, 0, r, co, ov, e, bn);
    check_eq("t3b_res", {32'd0, r}, 64'h7FFF_FFFF);
    check_eq("t3b_flags", {62'd0, co, ov}, 64'd3);
    repeat (3) @(negedge clock);

    // 4: start while busy is ignored; start in the DONE cycle chains directly.
    do_op(1'b0, 32'd10, 32'd20, 1'b0, 5, r, co, ov, e, bn);
    check_eq("t4a_edges", 64'(e), 64'd33);
    check_eq("t4a_res", {32'd0, r}, 64'd30);
    do_op(1'b0, 32'd2, 32'd2, 1'b1, 0, r, co, ov, e, bn);
    check_eq("t4b_edges", 64'(e), 64'd33);
    check_eq("t4b_res", {32'd0, r}, 64'd0);
    check_eq("t4b_flags", {62'd0, co, ov}, 64'd2);

    // 5: reset in the middle of an operation aborts it silently.
    drive(1'b0, 1'b1, 32'd100, 32'd1, 1'b0);
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_eq("t5_result", {32'd0, result32}, 64'd0);
    check_eq("t5_flags", {60'd0, co32, ov32, busy32, dr32}, 64'd0);
    check_eq("t5_state", 64'(d32.state_r), 64'(IDLE));
    cnt = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (dr32) cnt++;
    end
    check_eq("t5_no_ready", 64'(cnt), 64'd0);
    do_op(1'b0, 32'd6, 32'd7, 1'b0, 0, r, co, ov, e, bn);
    check_eq("t5_res", {32'd0, r}, 64'd13);

    // 6: narrow instance, directed overflow then random against a model.
    do_op(1'b1, 32'd7, 32'd1, 1'b0, 0, r, co, ov, e, bn);
    check_eq("t6_edges", 64'(e), 64'd5);
    check_eq("t6_res", {32'd0, r}, 64'd8);
    check_eq("t6_flags", {62'd0, co, ov}, 64'd1);
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {4'd0, rs};
      do_op(1'b1, {28'd0, ra}, {28'd0, rb}, rs, 0, r, co, ov, e, bn);
      check_eq("rnd_res", {32'd0, r}, {60'd0, full[3:0]});
      check_eq("rnd_co", {63'd0, co}, {63'd0, full[4]});
      check_eq("rnd_ov", {63'd0, ov}, {63'd0, (ra[3] == bb[3]) && (full[3] != ra[3])});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
